// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the PRBS pattern generator stream
//   (n repetitions of a 32-bit header pattern, MSB byte first, then PRBS-15 x^15+x^14+1).
// Latency: err, hdr_err, counters and in_check update on the edge that samples the byte
//   (visible the following cycle).
// Backpressure: none; the checker accepts every byte, and cycles with valid=0 are ignored.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   n, pattern            header repetition count (0 = 256) and header pattern / LFSR seed
//   data_in, valid        received byte and its qualifier
//   in_check              high while checking the PRBS payload
//   hdr_err               sticky header mismatch flag
//   err                   one-cycle pulse per mismatching byte
//   byte_err_cnt          saturating count of mismatching PRBS bytes
//   bit_err_cnt           saturating count of mismatching PRBS bits
module prbs_checker #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       n,
  input  logic [31:0]      pattern,
  input  logic [7:0]       data_in,
  input  logic             valid,
  output logic             in_check,
  output logic             hdr_err,
  output logic             err,
  output logic [CNT_W-1:0] byte_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [1:0]       byte_idx, byte_idx_nxt;
  logic [7:0]       rep, rep_nxt;
  logic [14:0]      lfsr, lfsr_nxt;
  logic             hdr_err_nxt, err_nxt;
  logic [CNT_W-1:0] byte_cnt_nxt, bit_cnt_nxt;

  logic [7:0]       hdr_exp;
  logic [7:0]       diff;
  logic [3:0]       diff_ones;
  logic [CNT_W:0]   bit_sum;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Expected header byte, MSB byte of the pattern first.
  always_comb begin
    hdr_exp = pattern[31:24];
    case (byte_idx)
      2'd0: hdr_exp = pattern[31:24];
      2'd1: hdr_exp = pattern[23:16];
      2'd2: hdr_exp = pattern[15:8];
      2'd3: hdr_exp = pattern[7:0];
    endcase
  end

  // In IDLE byte_idx is always 0, so hdr_exp already selects header byte 0.
  assign diff      = data_in ^ ((state == CHECK) ? lfsr[7:0] : hdr_exp);
  assign diff_ones = popcount8(diff);
  // One spare bit is enough: a byte adds at most 8 and CNT_W >= 4.
  assign bit_sum   = {1'b0, bit_err_cnt} + {{(CNT_W-3){1'b0}}, diff_ones};

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    rep_nxt      = rep;
    lfsr_nxt     = lfsr;
    hdr_err_nxt  = hdr_err;
    err_nxt      = 1'b0;
    byte_cnt_nxt = byte_err_cnt;
    bit_cnt_nxt  = bit_err_cnt;

    case (state)
      IDLE: begin
        lfsr_nxt = pattern[14:0];
        if (valid) begin
          if (diff != 8'h00) begin
            hdr_err_nxt = 1'b1;
            err_nxt     = 1'b1;
          end
          byte_idx_nxt = 2'd1;
          state_nxt    = HEADER;
        end
      end

      HEADER: begin
        lfsr_nxt = pattern[14:0];
        if (valid) begin
          // Mismatches do not disturb counting, so header alignment is kept.
          if (diff != 8'h00) begin
            hdr_err_nxt = 1'b1;
            err_nxt     = 1'b1;
          end
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // 8-bit wrap makes n=0 mean 256 repetitions.
            if (rep == n - 8'd1) begin
              state_nxt = CHECK;
            end else begin
              rep_nxt = rep + 8'd1;
            end
          end
        end
      end

      CHECK: begin
        if (valid) begin
          // Free-running: expectations never depend on received data.
          lfsr_nxt = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
          if (diff != 8'h00) begin
            err_nxt = 1'b1;
            if (byte_err_cnt != {CNT_W{1'b1}}) begin
              byte_cnt_nxt = byte_err_cnt + CNT_ONE;
            end
            bit_cnt_nxt = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      rep          <= 8'd0;
      lfsr         <= pattern[14:0];
      hdr_err      <= 1'b0;
      err          <= 1'b0;
      byte_err_cnt <= '0;
      bit_err_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      byte_idx     <= byte_idx_nxt;
      rep          <= rep_nxt;
      lfsr         <= lfsr_nxt;
      hdr_err      <= hdr_err_nxt;
      err          <= err_nxt;
      byte_err_cnt <= byte_cnt_nxt;
      bit_err_cnt  <= bit_cnt_nxt;
    end
  end

  assign in_check = (state == CHECK);

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (16-bit and 4-bit counters) share one stimulus.
// Expected values come from a stream model: header bytes from the pattern, PRBS bytes
// read as sliding 8-bit windows of the PRBS-15 bit sequence s[k+15] = s[k] ^ s[k+1].
module tb_prbs_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  n;
  logic [31:0] pattern;
  logic [7:0]  data_in;
  logic        valid;

  logic        in_check_a, hdr_err_a, err_a;
  logic [15:0] byte_a, bit_a;
  logic        in_check_b, hdr_err_b, err_b;
  logic [3:0]  byte_b, bit_b;

  always #5 CLK = ~CLK;

  prbs_checker #(.CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .n(n), .pattern(pattern), .data_in(data_in), .valid(valid),
    .in_check(in_check_a), .hdr_err(hdr_err_a), .err(err_a),
    .byte_err_cnt(byte_a), .bit_err_cnt(bit_a)
  );

  prbs_checker #(.CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .n(n), .pattern(pattern), .data_in(data_in), .valid(valid),
    .in_check(in_check_b), .hdr_err(hdr_err_b), .err(err_b),
    .byte_err_cnt(byte_b), .bit_err_cnt(bit_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit   s_bits [0:4199];
  int   k;          // valid bytes consumed since reset
  int   hdr_len;    // header length in bytes
  logic m_hdr;
  logic m_err;
  int   m_byte;
  int   m_bit;

  task automatic model_load();
    hdr_len = ((n == 8'd0) ? 256 : int'(n)) * 4;
    for (int i = 0; i < 15; i++) s_bits[i] = pattern[14 - i];
    for (int i = 15; i < 4200; i++) s_bits[i] = s_bits[i-15] ^ s_bits[i-14];
    k = 0; m_hdr = 1'b0; m_err = 1'b0; m_byte = 0; m_bit = 0;
  endtask

  function automatic logic [7:0] exp_byte(int pos);
    logic [7:0] b;
    int t;
    b = 8'h00;
    if (pos < hdr_len) begin
      b = 8'(pattern >> (8 * (3 - (pos % 4))));
    end else begin
      t = pos - hdr_len;
      for (int j = 0; j < 8; j++) b[7-j] = s_bits[t + 7 + j];
    end
    return b;
  endfunction

  function automatic logic [45:0] exp_vec();
    logic [15:0] b16, t16;
    logic [3:0]  b4, t4;
    logic        ic;
    b16 = (m_byte > 65535) ? 16'hFFFF : 16'(m_byte);
    t16 = (m_bit  > 65535) ? 16'hFFFF : 16'(m_bit);
    b4  = (m_byte > 15) ? 4'hF : 4'(m_byte);
    t4  = (m_bit  > 15) ? 4'hF : 4'(m_bit);
    ic  = (k >= hdr_len);
    return {m_err, m_hdr, ic, b16, t16, m_err, m_hdr, ic, b4, t4};
  endfunction

  function automatic logic [45:0] obs();
    return {err_a, hdr_err_a, in_check_a, byte_a, bit_a,
            err_b, hdr_err_b, in_check_b, byte_b, bit_b};
  endfunction

  // ---------------- stimulus drivers (no checking) ----------------
  task automatic drive_byte(input logic [7:0] d);
    logic [7:0] e;
    valid = 1'b1;
    data_in = d;
    e = exp_byte(k);
    @(posedge CLK);
    #1;
    valid = 1'b0;
    m_err = (d != e);
    if (k < hdr_len) begin
      if (d != e) m_hdr = 1'b1;
    end else if (d != e) begin
      m_byte = m_byte + 1;
      m_bit  = m_bit + $countones(d ^ e);
    end
    k = k + 1;
  endtask

  task automatic drive_gap();
    valid = 1'b0;
    data_in = 8'h55;
    @(posedge CLK);
    #1;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    valid = 1'b1;            // reset must win over a simultaneous byte
    data_in = 8'($urandom);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    valid = 1'b0;
    model_load();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pattern = $urandom;
    n = 8'($urandom_range(1, 4));
    do_reset();
    checks++;
    if (obs() !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", obs());
    end
  endtask

  task automatic test_clean();
    logic [63:0] hdr;
    hdr = 64'hDEADBEEF_DEADBEEF;
    pattern = 32'hDEADBEEF;
    n = 8'd2;
    do_reset();
    for (int j = 0; j < 108; j++) begin
      drive_byte(j < 8 ? hdr[63 - 8*j -: 8] : exp_byte(k));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL clean pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    checks++;
    if ({in_check_a, hdr_err_a, byte_a, bit_a} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL clean_final got ic=%b hdr=%b bytes=%0d bits=%0d exp 1 0 0 0",
               in_check_a, hdr_err_a, byte_a, bit_a);
    end
  endtask

  task automatic test_single_bit();
    logic [7:0] d;
    pattern = 32'hDEADBEEF;
    n = 8'd2;
    do_reset();
    for (int j = 0; j < 108; j++) begin
      d = exp_byte(k);
      if (j == 10) d = 8'hBF;   // 3rd PRBS byte, expected BE
      drive_byte(d);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL single_bit pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    checks++;
    if ({byte_a, bit_a} !== {16'd1, 16'd1}) begin
      errors++;
      $display("FAIL single_bit_counts got bytes=%0d bits=%0d exp 1 1", byte_a, bit_a);
    end
  endtask

  task automatic test_header_err();
    logic [7:0] d;
    pattern = 32'hDEADBEEF;
    n = 8'd2;
    do_reset();
    for (int j = 0; j < 108; j++) begin
      d = exp_byte(k);
      if (j == 2) d = 8'h00;
      drive_byte(d);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL header_err pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    checks++;
    if ({hdr_err_a, in_check_a, byte_a, bit_a} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL header_err_final got hdr=%b ic=%b bytes=%0d bits=%0d exp 1 1 0 0",
               hdr_err_a, in_check_a, byte_a, bit_a);
    end
  endtask

  task automatic test_gaps();
    int cyc;
    int first_ic;
    pattern = 32'hDEADBEEF;
    n = 8'd2;
    do_reset();
    cyc = 0;
    first_ic = -1;
    for (int j = 0; j < 38; j++) begin
      if (j == 4 || j == 18) begin
        for (int g = 0; g < 3; g++) begin
          drive_gap();
          cyc++;
          checks++;
          if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL gap pos=%0d got=%h exp=%h", k, obs(), exp_vec());
          end
        end
      end
      drive_byte(exp_byte(k));
      cyc++;
      if (first_ic < 0 && in_check_a === 1'b1) first_ic = cyc;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL gaps pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    checks++;
    if (first_ic !== 11) begin
      errors++;
      $display("FAIL gaps_in_check_cycle got=%0d exp=11", first_ic);
    end
  endtask

  task automatic test_saturation();
    pattern = $urandom;
    n = 8'd1;
    do_reset();
    for (int j = 0; j < 24; j++) begin
      drive_byte(j < 4 ? exp_byte(k) : ~exp_byte(k));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    checks++;
    if ({byte_b, bit_b, byte_a, bit_a} !== {4'hF, 4'hF, 16'd20, 16'd160}) begin
      errors++;
      $display("FAIL saturation_final got b4=%0d t4=%0d b16=%0d t16=%0d exp 15 15 20 160",
               byte_b, bit_b, byte_a, bit_a);
    end
  endtask

  task automatic test_reset_mid_check();
    // Continues from the CHECK state left by the saturation test.
    n = 8'd0;
    pattern = 32'h01234567;
    do_reset();
    checks++;
    if (obs() !== 46'd0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=0", obs());
    end
    for (int j = 0; j < 1024; j++) begin
      drive_byte(exp_byte(k));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL long_header pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
    drive_byte(8'h67);
    checks++;
    if ({in_check_a, err_a, in_check_b, err_b} !== 4'b1010) begin
      errors++;
      $display("FAIL first_prbs_67 got ic=%b err=%b exp ic=1 err=0", in_check_a, err_a);
    end
    for (int j = 0; j < 30; j++) begin
      drive_byte(($urandom_range(0, 3) == 0) ? exp_byte(k) ^ 8'($urandom_range(1, 255))
                                             : exp_byte(k));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL long_prbs pos=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int r = 0; r < 5; r++) begin
      pattern = $urandom;
      n = 8'($urandom_range(1, 3));
      do_reset();
      for (int j = 0; j < hdr_len + 60; j++) begin
        if ($urandom_range(0, 4) == 0) begin
          drive_gap();
          checks++;
          if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL random_gap run=%0d pos=%0d got=%h exp=%h", r, k, obs(), exp_vec());
          end
        end
        d = exp_byte(k);
        if ($urandom_range(0, 7) == 0) d = d ^ 8'($urandom_range(1, 255));
        drive_byte(d);
        checks++;
        if (obs() !== exp_vec()) begin
          errors++;
          $display("FAIL random run=%0d pos=%0d got=%h exp=%h", r, k, obs(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    valid = 1'b0;
    data_in = 8'h00;
    n = 8'd1;
    pattern = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_clean();
    test_single_bit();
    test_header_err();
    test_gaps();
    test_saturation();
    test_reset_mid_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker that consumes the byte stream produced by the team's PRBS pattern generator.
- The stream is a header of n repetitions of a 32-bit pattern, sent MSB byte first. It is followed by a PRBS-15 stream (x^15+x^14+1) seeded from pattern[14:0].
- The checker tracks the header, then regenerates the PRBS locally and reports byte and bit errors.
- It sits directly downstream of the generator in loopback/BIST benches.

Parameters:
CNT_W, 16, width of the saturating error counters.

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
n  input  8  header repetition count; 0 means 256; must be stable from reset release to end of header
pattern  input  32  header pattern and LFSR seed source (pattern[14:0]); same stability rule as n
data_in  input  8  received byte
valid  input  1  data_in holds a stream byte this cycle
in_check  output  1  high while in CHECK state
hdr_err  output  1  sticky; set on any header byte mismatch
err  output  1  one-cycle pulse, registered, for a mismatching byte
byte_err_cnt  output  CNT_W  count of mismatching PRBS bytes, saturating
bit_err_cnt  output  CNT_W  count of mismatching PRBS bits, saturating

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, byte_idx=0, rep=0, lfsr=pattern[14:0]. All outputs 0.
- Reset mid-operation gives the same result; no residue from the previous run.
- valid=0: the cycle has no effect. No state, index or LFSR advance; err=0.
- Expected header byte for byte_idx 0..3: pattern[31:24], [23:16], [15:8], [7:0].
- IDLE: lfsr reloads pattern[14:0] every cycle.
  - On valid, compare data_in to byte 0, set byte_idx=1, go to HEADER.
- HEADER: lfsr reloads pattern[14:0] every cycle.
  - On valid, compare data_in to the expected byte for byte_idx.
  - byte_idx advances 0→1→2→3→0.
  - At byte_idx=3: if rep==n-1 (8-bit wrap, so n=0 gives 256 reps), go to CHECK; otherwise rep++.
- Header mismatch: hdr_err<=1 (sticky until reset) and err pulses. Counting continues, so alignment is kept.
- CHECK: on valid, expected byte = lfsr[7:0].
  - Compare, then lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}.
  - The first CHECK byte equals pattern[7:0] (the seed's low byte).
  - The lfsr is free-running and never reloaded from data, so a corrupted byte does not affect later expectations.
- CHECK mismatch: err pulses.
  - byte_err_cnt += 1.
  - bit_err_cnt += popcount(data_in ^ expected).
  - Both counters saturate at all-ones; the add is clamped, not wrapped.
- CHECK is exited only by reset.
- Latency: err, counters, hdr_err and in_check update on the clock edge that samples the byte, i.e. they are visible the cycle after data_in.
  - in_check rises the cycle after the last header byte is sampled.
- Simultaneous RST and valid: reset wins and the byte is discarded.

Test Plan:
1. Clean run: pattern=32'hDEADBEEF, n=2, valid every cycle. Send DE AD BE EF DE AD BE EF, then PRBS EF DF BE … (100 bytes).
   → in_check=1 after the 8th byte; err never pulses; hdr_err=0; both counts 0.
2. Single-bit PRBS error: same stream as 1, with the 3rd PRBS byte sent as 8'hBF instead of 8'hBE.
   → err pulses one cycle later; byte_err_cnt=1; bit_err_cnt=1; all later bytes match.
3. Header error: the 3rd header byte is sent as 8'h00.
   → hdr_err=1 stays high; err pulses once; in_check still rises after 8 bytes; counts 0 after a clean PRBS stream.
4. valid gaps: drop valid for 3 cycles at header byte 5 and again after PRBS byte 10, with data_in=8'h55 during the gaps.
   → no err; in_check timing shifts by exactly 3 valid-low cycles; counts 0.
5. Saturation: CNT_W=4; send 20 PRBS bytes, each the bitwise inverse of the expected byte.
   → byte_err_cnt=15 and bit_err_cnt=15 held; err pulses on all 20 bytes.
6. Reset mid-CHECK: assert RST for 1 cycle.
   → all outputs 0 next cycle. Then set n=0, pattern=32'h01234567.
   → in_check rises only after 1024 header bytes; first PRBS byte expected 8'h67.
